// File: rtl/qe_sample_scheduler.sv
// Periodic sweep controller for the quadrature-encoder channel array: snapshots each
// channel's count over a req/ack handshake and reports the signed change since the last snapshot.
module qe_sample_scheduler #(
  parameter int NOS_CHANNELS = 4,
  parameter int ACK_TIMEOUT  = 16,
  localparam int CW = (NOS_CHANNELS > 1) ? $clog2(NOS_CHANNELS) : 1,
  localparam int TW = $clog2(ACK_TIMEOUT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [31:0]             sample_period,
  input  logic                    clear_errors,
  output logic [CW-1:0]           ch_sel,
  output logic                    sample_req,
  input  logic                    sample_ack,
  input  logic [31:0]             sample_count,
  output logic [31:0]             delta_out,
  output logic [CW-1:0]           delta_ch,
  output logic                    delta_valid,
  output logic                    cycle_done,
  output logic                    busy,
  output logic [NOS_CHANNELS-1:0] timeout_err,
  output logic                    overrun,
  output logic [2:0]              dbg_state
);

  // Handshake: sample_req rises on entry to REQUEST and stays high until the clock
  // after sample_ack is seen in WAIT_ACK (or the wait times out); the channel must hold
  // sample_count valid in the same cycle it raises sample_ack.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    REQUEST   = 3'd2,
    WAIT_ACK  = 3'd3,
    STORE     = 3'd4,
    NEXT      = 3'd5
  } state_t;

  state_t                  state;
  logic [31:0]             pcnt;
  logic [31:0]             period_q;
  logic [31:0]             period_eff;
  logic                    run;
  logic                    tick;
  logic [TW-1:0]           to_cnt;
  logic [31:0]             cap;
  logic [31:0]             last [NOS_CHANNELS];
  logic [NOS_CHANNELS-1:0] primed;

  // A new period value is only picked up while the counter sits at zero (i.e. at reload).
  assign period_eff = (pcnt == 32'd0) ? sample_period : period_q;
  assign run        = enable && (period_eff != 32'd0);
  assign tick       = run && (pcnt == period_eff - 32'd1);

  assign busy      = (state == REQUEST) || (state == WAIT_ACK) ||
                     (state == STORE)   || (state == NEXT);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt     <= '0;
      period_q <= '0;
    end else begin
      period_q <= period_eff;
      if (!run || tick) pcnt <= '0;
      else              pcnt <= pcnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ch_sel      <= '0;
      sample_req  <= 1'b0;
      delta_out   <= '0;
      delta_ch    <= '0;
      delta_valid <= 1'b0;
      cycle_done  <= 1'b0;
      timeout_err <= '0;
      overrun     <= 1'b0;
      to_cnt      <= '0;
      cap         <= '0;
      primed      <= '0;
      for (int i = 0; i < NOS_CHANNELS; i++) last[i] <= '0;
    end else begin
      delta_valid <= 1'b0;
      cycle_done  <= 1'b0;

      // Setting an error takes priority over a simultaneous clear.
      if (tick && busy)      overrun <= 1'b1;
      else if (clear_errors) overrun <= 1'b0;
      if (clear_errors) timeout_err <= '0;

      if (!enable) begin
        state      <= IDLE;
        sample_req <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= WAIT_TICK;

          WAIT_TICK: begin
            if (tick) begin
              ch_sel     <= '0;
              sample_req <= 1'b1;
              state      <= REQUEST;
            end
          end

          REQUEST: begin
            to_cnt <= '0;
            state  <= WAIT_ACK;
          end

          WAIT_ACK: begin
            if (sample_ack) begin
              cap        <= sample_count;
              sample_req <= 1'b0;
              state      <= STORE;
            end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
              timeout_err[ch_sel] <= 1'b1;
              sample_req          <= 1'b0;
              state               <= NEXT;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end

          STORE: begin
            // First snapshot of a channel only establishes the baseline.
            delta_out      <= primed[ch_sel] ? (cap - last[ch_sel]) : 32'd0;
            delta_ch       <= ch_sel;
            delta_valid    <= 1'b1;
            last[ch_sel]   <= cap;
            primed[ch_sel] <= 1'b1;
            state          <= NEXT;
          end

          NEXT: begin
            if (ch_sel == CW'(NOS_CHANNELS - 1)) begin
              cycle_done <= 1'b1;
              state      <= WAIT_TICK;
            end else begin
              ch_sel     <= ch_sel + CW'(1);
              sample_req <= 1'b1;
              state      <= REQUEST;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qe_sample_scheduler.sv
// Directed bench for qe_sample_scheduler: sweeps, wrap, timeout, overrun, abort and reset.
module tb_qe_sample_scheduler;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] sample_period;
  logic        clear_errors;
  logic [1:0]  ch_sel;
  logic        sample_req;
  logic        sample_ack;
  logic [31:0] sample_count;
  logic [31:0] delta_out;
  logic [1:0]  delta_ch;
  logic        delta_valid;
  logic        cycle_done;
  logic        busy;
  logic [3:0]  timeout_err;
  logic        overrun;
  logic [2:0]  dbg_state;

  int vec;
  int errs;
  logic [31:0] cnt_v [4];
  logic [31:0] exp_v [4];

  qe_sample_scheduler #(.NOS_CHANNELS(4), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_period(sample_period),
    .clear_errors(clear_errors), .ch_sel(ch_sel), .sample_req(sample_req),
    .sample_ack(sample_ack), .sample_count(sample_count), .delta_out(delta_out),
    .delta_ch(delta_ch), .delta_valid(delta_valid), .cycle_done(cycle_done),
    .busy(busy), .timeout_err(timeout_err), .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int ch);
    int n;
    n = 0;
    while (sample_req !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    vec++;
    if (sample_req !== 1'b1) begin
      errs++;
      $display("FAIL req_wait ch%0d: sample_req=%b after %0d clocks, required 1", ch, sample_req, n);
    end
    vec++;
    if (ch_sel !== 2'(ch)) begin
      errs++;
      $display("FAIL ch_order: ch_sel=%0d, required %0d", ch_sel, ch);
    end
  endtask

  // Ack 'dly' clocks after the request is seen; expect the delta two clocks after the ack.
  task automatic do_channel(input int ch, input logic [31:0] cnt, input int dly,
                            input logic [31:0] exp_d);
    wait_req(ch);
    repeat (dly) step();
    sample_ack   = 1'b1;
    sample_count = cnt;
    step();
    sample_ack   = 1'b0;
    sample_count = 32'hDEAD_BEEF;
    vec++;
    if (sample_req !== 1'b0 || delta_valid !== 1'b0) begin
      errs++;
      $display("FAIL store_cycle ch%0d: req=%b dv=%b, required 0 0", ch, sample_req, delta_valid);
    end
    step();
    vec++;
    if (delta_valid !== 1'b1 || delta_out !== exp_d || delta_ch !== 2'(ch)) begin
      errs++;
      $display("FAIL delta ch%0d: dv=%b out=%h ch=%0d, required 1 %h %0d",
               ch, delta_valid, delta_out, delta_ch, exp_d, ch);
    end
  endtask

  task automatic run_sweep(input int dly);
    for (int c = 0; c < 4; c++) do_channel(c, cnt_v[c], dly, exp_v[c]);
    step();
    vec++;
    if (cycle_done !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL cycle_done: done=%b busy=%b, required 1 0", cycle_done, busy);
    end
  endtask

  task automatic check_all_zero(input string tag);
    vec++;
    if ({sample_req, busy, delta_valid, cycle_done, overrun} !== 5'b0 ||
        ch_sel !== 2'd0 || delta_ch !== 2'd0 || delta_out !== 32'd0 ||
        timeout_err !== 4'd0 || dbg_state !== 3'd0) begin
      errs++;
      $display("FAIL %s: req=%b busy=%b dv=%b done=%b ovr=%b ch=%0d dch=%0d dout=%h terr=%b st=%0d, required all 0",
               tag, sample_req, busy, delta_valid, cycle_done, overrun, ch_sel, delta_ch,
               delta_out, timeout_err, dbg_state);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; sample_period = 32'd0; clear_errors = 1'b0;
    sample_ack = 1'b0; sample_count = 32'd0;
    repeat (3) step();
    check_all_zero("reset_state");
    reset = 1'b0;
    step();
  endtask

  task automatic test_zero_period();
    int seen;
    seen = 0;
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy !== 1'b0 || sample_req !== 1'b0) seen++;
    end
    vec++;
    if (seen != 0) begin
      errs++;
      $display("FAIL zero_period: %0d busy clocks, required 0", seen);
    end
    sample_period = 32'd100;
  endtask

  task automatic test_basic_sweeps();
    cnt_v = '{32'd10, 32'd20, 32'd30, 32'd40};
    exp_v = '{32'd0, 32'd0, 32'd0, 32'd0};
    run_sweep(1);
    cnt_v = '{32'd15, 32'd20, 32'd25, 32'd50};
    exp_v = '{32'd5, 32'd0, 32'hFFFF_FFFB, 32'd10};
    run_sweep(1);
    vec++;
    if (overrun !== 1'b0 || timeout_err !== 4'd0) begin
      errs++;
      $display("FAIL basic_errors: ovr=%b terr=%b, required 0 0000", overrun, timeout_err);
    end
  endtask

  task automatic test_wrap();
    cnt_v = '{32'hFFFF_FFFE, 32'd20, 32'd25, 32'd50};
    exp_v = '{32'hFFFF_FFEF, 32'd0, 32'd0, 32'd0};
    run_sweep(1);
    cnt_v = '{32'h0000_0003, 32'd20, 32'd25, 32'd50};
    exp_v = '{32'd5, 32'd0, 32'd0, 32'd0};
    run_sweep(1);
  endtask

  task automatic test_timeout();
    do_channel(0, 32'd3, 1, 32'd0);
    do_channel(1, 32'd20, 1, 32'd0);
    wait_req(2);
    repeat (16) step();
    vec++;
    if (timeout_err !== 4'b0000 || sample_req !== 1'b1) begin
      errs++;
      $display("FAIL timeout_early: terr=%b req=%b, required 0000 1", timeout_err, sample_req);
    end
    step();
    vec++;
    if (timeout_err !== 4'b0100 || sample_req !== 1'b0 || delta_valid !== 1'b0) begin
      errs++;
      $display("FAIL timeout_set: terr=%b req=%b dv=%b, required 0100 0 0",
               timeout_err, sample_req, delta_valid);
    end
    do_channel(3, 32'd50, 1, 32'd0);
    step();
    vec++;
    if (cycle_done !== 1'b1) begin
      errs++;
      $display("FAIL timeout_sweep_done: done=%b, required 1", cycle_done);
    end
    clear_errors = 1'b1;
    step();
    clear_errors = 1'b0;
    vec++;
    if (timeout_err !== 4'b0000) begin
      errs++;
      $display("FAIL timeout_clear: terr=%b, required 0000", timeout_err);
    end
  endtask

  task automatic test_overrun();
    sample_period = 32'd8;
    cnt_v = '{32'd10, 32'd20, 32'd30, 32'd60};
    exp_v = '{32'd7, 32'd0, 32'd5, 32'd10};
    run_sweep(5);
    vec++;
    if (overrun !== 1'b1 || timeout_err !== 4'd0) begin
      errs++;
      $display("FAIL overrun_set: ovr=%b terr=%b, required 1 0000", overrun, timeout_err);
    end
    enable = 1'b0;
    step();
    sample_period = 32'd100;
    clear_errors = 1'b1;
    step();
    clear_errors = 1'b0;
    vec++;
    if (overrun !== 1'b0) begin
      errs++;
      $display("FAIL overrun_clear: ovr=%b, required 0", overrun);
    end
  endtask

  task automatic test_abort();
    int bad;
    enable = 1'b1;
    do_channel(0, 32'd12, 1, 32'd2);
    wait_req(1);
    step();
    vec++;
    if (dbg_state !== 3'd3) begin
      errs++;
      $display("FAIL abort_pre_state: st=%0d, required 3", dbg_state);
    end
    enable = 1'b0;
    step();
    vec++;
    if (sample_req !== 1'b0 || dbg_state !== 3'd0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL abort_idle: req=%b st=%0d busy=%b, required 0 0 0", sample_req, dbg_state, busy);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cycle_done !== 1'b0 || delta_valid !== 1'b0) bad++;
    end
    vec++;
    if (bad != 0) begin
      errs++;
      $display("FAIL abort_quiet: %0d strobes, required 0", bad);
    end
    enable = 1'b1;
    cnt_v = '{32'd13, 32'd20, 32'd30, 32'd60};
    exp_v = '{32'd1, 32'd0, 32'd0, 32'd0};
    run_sweep(1);
  endtask

  task automatic test_reset_mid_sweep();
    do_channel(0, 32'd100, 1, 32'd87);
    wait_req(1);
    step();
    reset = 1'b1;
    step();
    check_all_zero("reset_mid_sweep");
    reset = 1'b0;
    cnt_v = '{32'd5, 32'd6, 32'd7, 32'd8};
    exp_v = '{32'd0, 32'd0, 32'd0, 32'd0};
    run_sweep(1);
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    test_reset();
    test_zero_period();
    test_basic_sweeps();
    test_wrap();
    test_timeout();
    test_overrun();
    test_abort();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
